// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control unit driving datapath strobes from state and IR
module control_sequencer #(
    parameter int              OP_W   = 5,
    parameter logic [OP_W-1:0] ADD_OP = 5'b00011
) (
    input  logic            Clock,
    input  logic            clear,
    input  logic [31:0]     IR,
    input  logic            CON_FF,
    input  logic            Stop,
    output logic            Run,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic            PCin,
    output logic            PCout,
    output logic            IncPC,
    output logic            IRin,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            Yin,
    output logic            Zin,
    output logic            Zlowout,
    output logic            Zhighout,
    output logic            Cout,
    output logic            HIin,
    output logic            HIout,
    output logic            LOin,
    output logic            LOout,
    output logic            CONin,
    output logic            Inportout,
    output logic            Outportin,
    output logic            Read,
    output logic            Write,
    output logic [OP_W-1:0] opcode
);
    typedef enum logic [3:0] {RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
    localparam logic [OP_W-1:0] OP_JAL  = 5'b10100;
    localparam logic [OP_W-1:0] OP_IN   = 5'b10101;
    localparam logic [OP_W-1:0] OP_OUT  = 5'b10110;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b10111;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

    state_t state, next;
    logic   done;
    logic   unused_ir;

    wire logic [OP_W-1:0] op = IR[31:32-OP_W];
    wire logic is_r    = (op >= OP_ADD) && (op <= OP_OR);
    wire logic is_imm  = (op >= OP_ADDI) && (op <= OP_ORI);
    wire logic is_ld   = op == OP_LD;
    wire logic is_ldi  = op == OP_LDI;
    wire logic is_st   = op == OP_ST;
    wire logic is_mem  = is_ld || is_ldi || is_st;
    wire logic is_md   = (op == OP_MUL) || (op == OP_DIV);
    wire logic is_nn   = (op == OP_NEG) || (op == OP_NOT);
    wire logic is_br   = op == OP_BR;
    wire logic is_jal  = op == OP_JAL;
    wire logic use_add = is_mem || is_br;

    assign unused_ir = ^IR[31-OP_W:0];

    // state register; clear wins over every transition, including HALT
    always_ff @(posedge Clock) begin
        if (clear) state <= RESET;
        else       state <= next;
    end

    // next-state and strobe decode from the current step and the opcode class
    always_comb begin
        next = state;
        done = 1'b0;
        Run = 1'b0;
        opcode = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
        {PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout} = '0;
        {Yin, Zin, Zlowout, Zhighout, Cout, HIin, HIout, LOin, LOout} = '0;
        {CONin, Inportout, Outportin, Read, Write} = '0;
        case (state)
            RESET: next = T0;
            T0: begin
                {PCout, MARin, IncPC, Zin} = '1;
                next = T1;
            end
            T1: begin
                {Zlowout, PCin, Read, MDRin} = '1;
                next = T2;
            end
            T2: begin
                {MDRout, IRin} = '1;
                next = T3;
            end
            T3: begin
                next = T4;
                if (is_r || is_imm)     {Grb, Rout, Yin} = '1;
                else if (is_mem)        {Grb, BAout, Yin} = '1;
                else if (is_md)         {Gra, Rout, Yin} = '1;
                else if (is_nn)         {Grb, Rout, Zin} = '1;
                else if (is_br)         {Gra, Rout, CONin} = '1;
                else if (is_jal)        {PCout, Grb, Rin} = '1;
                else if (op == OP_JR)   {Gra, Rout, PCin, done} = '1;
                else if (op == OP_IN)   {Inportout, Gra, Rin, done} = '1;
                else if (op == OP_OUT)  {Gra, Rout, Outportin, done} = '1;
                else if (op == OP_MFHI) {HIout, Gra, Rin, done} = '1;
                else if (op == OP_MFLO) {LOout, Gra, Rin, done} = '1;
                else if (op == OP_HALT) next = HALT;
                else                    done = 1'b1;
            end
            T4: begin
                next = T5;
                if (is_r)                 {Grc, Rout, Zin} = '1;
                else if (is_imm || is_mem) {Cout, Zin} = '1;
                else if (is_md)           {Grb, Rout, Zin} = '1;
                else if (is_nn)           {Zlowout, Gra, Rin, done} = '1;
                else if (is_br)           {PCout, Yin} = '1;
                else if (is_jal)          {Gra, Rout, PCin, done} = '1;
                else                      done = 1'b1;
            end
            T5: begin
                next = T6;
                if (is_r || is_imm || is_ldi) {Zlowout, Gra, Rin, done} = '1;
                else if (is_ld || is_st)      {Zlowout, MARin} = '1;
                else if (is_md)               {Zlowout, LOin} = '1;
                else if (is_br)               {Cout, Zin} = '1;
                else                          done = 1'b1;
            end
            T6: begin
                next = T7;
                if (is_ld)      {Read, MDRin} = '1;
                else if (is_st) {Gra, Rout, MDRin} = '1;
                else if (is_md) {Zhighout, HIin, done} = '1;
                else if (is_br) begin
                    Zlowout = 1'b1;
                    PCin = CON_FF;
                    done = 1'b1;
                end
                else            done = 1'b1;
            end
            T7: begin
                if (is_ld)      {MDRout, Gra, Rin} = '1;
                else if (is_st) Write = 1'b1;
                done = 1'b1;
            end
            HALT: next = HALT;
            default: next = RESET;
        endcase
        if (state != RESET && state != HALT) begin
            Run = 1'b1;
            opcode = use_add ? ADD_OP : op;
        end
        if (done) next = Stop ? HALT : T0;
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed instruction walks with a queued scoreboard checking every cycle's strobes
module tb_control_sequencer;
    logic        Clock = 1'b0;
    logic        clear, CON_FF, Stop;
    logic [31:0] IR;
    logic Run, Gra, Grb, Grc, Rin, Rout, BAout, PCin, PCout, IncPC, IRin, MARin, MDRin, MDRout;
    logic Yin, Zin, Zlowout, Zhighout, Cout, HIin, HIout, LOin, LOout, CONin, Inportout, Outportin;
    logic Read, Write;
    logic [4:0] opcode;

    localparam logic [27:0] RUN = 28'd1 << 0, GRA = 28'd1 << 1, GRB = 28'd1 << 2, GRC = 28'd1 << 3;
    localparam logic [27:0] RIN = 28'd1 << 4, ROUT = 28'd1 << 5, BAOUT = 28'd1 << 6, PCIN = 28'd1 << 7;
    localparam logic [27:0] PCOUT = 28'd1 << 8, INCPC = 28'd1 << 9, IRIN = 28'd1 << 10, MARIN = 28'd1 << 11;
    localparam logic [27:0] MDRIN = 28'd1 << 12, MDROUT = 28'd1 << 13, YIN = 28'd1 << 14, ZIN = 28'd1 << 15;
    localparam logic [27:0] ZLOWOUT = 28'd1 << 16, ZHIGHOUT = 28'd1 << 17, COUT = 28'd1 << 18, HIIN = 28'd1 << 19;
    localparam logic [27:0] HIOUT = 28'd1 << 20, LOIN = 28'd1 << 21, LOOUT = 28'd1 << 22, CONIN = 28'd1 << 23;
    localparam logic [27:0] INPORTOUT = 28'd1 << 24, OUTPORTIN = 28'd1 << 25, READ = 28'd1 << 26, WRITE = 28'd1 << 27;

    control_sequencer dut (
        .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .Run(Run),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
        .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout), .Cout(Cout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .CONin(CONin), .Inportout(Inportout), .Outportin(Outportin),
        .Read(Read), .Write(Write), .opcode(opcode)
    );

    wire logic [32:0] got = {opcode, Write, Read, Outportin, Inportout, CONin, LOout, LOin, HIout, HIin,
                             Cout, Zhighout, Zlowout, Zin, Yin, MDRout, MDRin, MARin, IRin, IncPC,
                             PCout, PCin, BAout, Rout, Rin, Grc, Grb, Gra, Run};

    logic [32:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 Clock = ~Clock;

    // monitor: compare each cycle's outputs against the oldest queued expectation
    always @(negedge Clock) begin
        logic [32:0] e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got opcode=%b strobes=%h, expected opcode=%b strobes=%h",
                         n, got[32:28], got[27:0], e[32:28], e[27:0]);
            end
        end
    end

    task automatic cyc(input string nm, input logic [27:0] m, input logic [4:0] op);
        exp_q.push_back({op, m});
        name_q.push_back(nm);
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch(input string nm, input logic [4:0] op);
        cyc({nm, " T0"}, RUN | PCOUT | MARIN | INCPC | ZIN, op);
        cyc({nm, " T1"}, RUN | ZLOWOUT | PCIN | READ | MDRIN, op);
        cyc({nm, " T2"}, RUN | MDROUT | IRIN, op);
    endtask

    task automatic instr(input string nm, input logic [31:0] ir, input logic [4:0] op, input int n,
                         input logic [27:0] s3, input logic [27:0] s4, input logic [27:0] s5,
                         input logic [27:0] s6, input logic [27:0] s7);
        logic [27:0] s [5];
        s = '{s3, s4, s5, s6, s7};
        IR = ir;
        fetch(nm, op);
        for (int i = 0; i < n; i++) cyc($sformatf("%s T%0d", nm, i + 3), RUN | s[i], op);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
        $fatal(1);
    end

    initial begin
        clear = 1'b1; IR = '0; Stop = 1'b0; CON_FF = 1'b0;
        @(posedge Clock);
        #1;
        cyc("reset0", '0, '0);
        clear = 1'b0;
        cyc("reset1", '0, '0);
        instr("add", 32'h18918000, 5'b00011, 3, GRB | ROUT | YIN, GRC | ROUT | ZIN, ZLOWOUT | GRA | RIN, '0, '0);
        CON_FF = 1'b1;
        instr("br_taken", 32'h91000023, 5'b00011, 4, GRA | ROUT | CONIN, PCOUT | YIN, COUT | ZIN, ZLOWOUT | PCIN, '0);
        IR = 32'h91000023;
        fetch("br_not", 5'b00011);
        cyc("br_not T3", RUN | GRA | ROUT | CONIN, 5'b00011);
        cyc("br_not T4", RUN | PCOUT | YIN, 5'b00011);
        cyc("br_not T5", RUN | COUT | ZIN, 5'b00011);
        CON_FF = 1'b0;
        cyc("br_not T6", RUN | ZLOWOUT, 5'b00011);
        instr("ld", 32'h00900054, 5'b00011, 5, GRB | BAOUT | YIN, COUT | ZIN, ZLOWOUT | MARIN, READ | MDRIN, MDROUT | GRA | RIN);
        instr("st", 32'h1100002A, 5'b00011, 5, GRB | BAOUT | YIN, COUT | ZIN, ZLOWOUT | MARIN, GRA | ROUT | MDRIN, WRITE);
        instr("ldi", 32'h08800005, 5'b00011, 3, GRB | BAOUT | YIN, COUT | ZIN, ZLOWOUT | GRA | RIN, '0, '0);
        instr("and", 32'h48918000, 5'b01001, 3, GRB | ROUT | YIN, GRC | ROUT | ZIN, ZLOWOUT | GRA | RIN, '0, '0);
        instr("addi", 32'h58900007, 5'b01011, 3, GRB | ROUT | YIN, COUT | ZIN, ZLOWOUT | GRA | RIN, '0, '0);
        instr("div", 32'h79100000, 5'b01111, 4, GRA | ROUT | YIN, GRB | ROUT | ZIN, ZLOWOUT | LOIN, ZHIGHOUT | HIIN, '0);
        instr("neg", 32'h80880000, 5'b10000, 2, GRB | ROUT | ZIN, ZLOWOUT | GRA | RIN, '0, '0, '0);
        instr("jal", 32'hA0800000, 5'b10100, 2, PCOUT | GRB | RIN, GRA | ROUT | PCIN, '0, '0, '0);
        instr("jr", 32'h98800000, 5'b10011, 1, GRA | ROUT | PCIN, '0, '0, '0, '0);
        instr("in", 32'hA8800000, 5'b10101, 1, INPORTOUT | GRA | RIN, '0, '0, '0, '0);
        instr("out", 32'hB0800000, 5'b10110, 1, GRA | ROUT | OUTPORTIN, '0, '0, '0, '0);
        instr("mfhi", 32'hB8800000, 5'b10111, 1, HIOUT | GRA | RIN, '0, '0, '0, '0);
        instr("mflo", 32'hC0800000, 5'b11000, 1, LOOUT | GRA | RIN, '0, '0, '0, '0);
        instr("nop", 32'hC8000000, 5'b11001, 1, '0, '0, '0, '0, '0);
        instr("undef", 32'hF8000000, 5'b11111, 1, '0, '0, '0, '0, '0);
        IR = 32'h71100000;
        fetch("mul", 5'b01110);
        cyc("mul T3", RUN | GRA | ROUT | YIN, 5'b01110);
        clear = 1'b1;
        cyc("mul T4", RUN | GRB | ROUT | ZIN, 5'b01110);
        clear = 1'b0;
        cyc("mul cleared", '0, '0);
        instr("halt", 32'hD0000000, 5'b11010, 1, '0, '0, '0, '0, '0);
        for (int i = 0; i < 20; i++) begin
            Stop = i[0];
            CON_FF = i[1];
            cyc("halted", '0, '0);
        end
        Stop = 1'b0;
        clear = 1'b1;
        cyc("halt clear edge", '0, '0);
        clear = 1'b0;
        cyc("halt reset", '0, '0);
        IR = 32'h18918000;
        fetch("add_stop", 5'b00011);
        Stop = 1'b1;
        cyc("add_stop T3", RUN | GRB | ROUT | YIN, 5'b00011);
        cyc("add_stop T4", RUN | GRC | ROUT | ZIN, 5'b00011);
        cyc("add_stop T5", RUN | ZLOWOUT | GRA | RIN, 5'b00011);
        Stop = 1'b0;
        for (int i = 0; i < 3; i++) cyc("stop halted", '0, '0);
        clear = 1'b1;
        cyc("stop clear edge", '0, '0);
        clear = 1'b0;
        cyc("stop reset", '0, '0);
        instr("nop_end", 32'hC8000000, 5'b11001, 1, '0, '0, '0, '0, '0);
        #20;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
